// File: rtl/axi4s_frame_gen.sv
// Purpose : AXI4-Stream test-frame generator; emits num_frames frames of len bytes with an incrementing byte pattern.
// Latency : first beat valid on the cycle after start is accepted; back-to-back beats while tready is high.
// Backpr. : stalls on s_tready_i low, holding tdata/tkeep/tlast/tvalid stable until the beat transfers.
// Config  : define AXI4S_FRAME_GEN_GAP_EN to insert IFG_CYCLES idle cycles between frames.
module axi4s_frame_gen #(
   parameter int AXI_WIDTH  = 64,
   parameter int IFG_CYCLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [15:0]            len_bytes_i,
   input  logic [15:0]            num_frames_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [15:0]            frames_sent_o,
   output logic [AXI_WIDTH-1:0]   s_tdata_o,
   output logic                   s_tvalid_o,
   input  logic                   s_tready_i,
   output logic                   s_tlast_o,
   output logic [AXI_WIDTH/8-1:0] s_tkeep_o
);

   localparam int          KW       = AXI_WIDTH / 8;
   localparam logic [15:0] KW16     = 16'(KW);
   localparam logic [7:0]  KW8      = 8'(KW);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;     // frame length captured at start
   logic [15:0] nfr_q, nfr_d;     // frame count captured at start
   logic [15:0] rem_q, rem_d;     // bytes still to send in the current frame, including this beat
   logic [7:0]  off_q, off_d;     // low byte of the in-frame byte offset of lane 0
   logic [15:0] sent_q, sent_d;   // completed frames; also the index of the frame being sent
   logic [7:0]  gap_q, gap_d;     // idle cycles already spent in GAP

   logic beat_acc;
   logic last_beat;
   logic final_frame;

   // The current beat is the last of its frame once no more than one beat of bytes remains.
   assign last_beat   = (rem_q <= KW16);
   assign beat_acc    = (state_q == SEND) && s_tready_i;
   assign final_frame = ((sent_q + 16'd1) == nfr_q);

   // State and run registers; async reset returns to IDLE with everything cleared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         len_q   <= '0;
         nfr_q   <= '0;
         rem_q   <= '0;
         off_q   <= '0;
         sent_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         nfr_q   <= nfr_d;
         rem_q   <= rem_d;
         off_q   <= off_d;
         sent_q  <= sent_d;
         gap_q   <= gap_d;
      end
   end

   // Next-state logic: run capture, beat/frame bookkeeping and inter-frame gap timing.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      nfr_d   = nfr_q;
      rem_d   = rem_q;
      off_d   = off_q;
      sent_d  = sent_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d  = len_bytes_i;
               nfr_d  = num_frames_i;
               rem_d  = len_bytes_i;
               off_d  = '0;
               sent_d = '0;
               gap_d  = '0;
               if ((len_bytes_i != 16'd0) && (num_frames_i != 16'd0)) begin
                  state_d = SEND;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SEND: begin
            if (beat_acc) begin
               if (last_beat) begin
                  sent_d = sent_q + 16'd1;
                  rem_d  = len_q;
                  off_d  = '0;
                  if (final_frame) begin
                     state_d = DONE;
                  end else begin
`ifdef AXI4S_FRAME_GEN_GAP_EN
                     state_d = GAP;
                     gap_d   = '0;
`else
                     state_d = SEND;
`endif
                  end
               end else begin
                  rem_d = rem_q - KW16;
                  off_d = off_q + KW8;
               end
            end
         end
         GAP: begin
            if (gap_q == IFG_LAST) begin
               state_d = SEND;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stream outputs derived from registered state only, so they stay stable during a stall.
   always_comb begin
      logic [7:0]           byte_v;
      logic [AXI_WIDTH-1:0] dat_v;
      logic [KW-1:0]        keep_v;
      dat_v  = '0;
      keep_v = '0;
      byte_v = '0;
      for (int i = 0; i < KW; i++) begin
         keep_v[i] = !last_beat || (16'(i) < rem_q);
         byte_v    = sent_q[7:0] + off_q + 8'(i);
         dat_v[i*8 +: 8] = keep_v[i] ? byte_v : 8'h00;
      end
      s_tvalid_o = (state_q == SEND);
      s_tlast_o  = (state_q == SEND) && last_beat;
      s_tkeep_o  = (state_q == SEND) ? keep_v : '0;
      s_tdata_o  = (state_q == SEND) ? dat_v : '0;
   end

   // Status outputs.
   always_comb begin
      busy_o        = (state_q != IDLE);
      done_o        = (state_q == DONE);
      frames_sent_o = sent_q;
   end

endmodule

// File: tb/tb_axi4s_frame_gen.sv
module tb_axi4s_frame_gen;

   localparam int W   = 64;
   localparam int KW  = W / 8;
   localparam int IFG = 4;
`ifdef AXI4S_FRAME_GEN_GAP_EN
   localparam int GAPX = IFG;
`else
   localparam int GAPX = 0;
`endif

   logic          clk_i;
   logic          rst_ni;
   logic          start_i;
   logic [15:0]   len_bytes_i;
   logic [15:0]   num_frames_i;
   logic          busy_o;
   logic          done_o;
   logic [15:0]   frames_sent_o;
   logic [W-1:0]  s_tdata_o;
   logic          s_tvalid_o;
   logic          s_tready_i;
   logic          s_tlast_o;
   logic [KW-1:0] s_tkeep_o;

   axi4s_frame_gen #(.AXI_WIDTH(W), .IFG_CYCLES(IFG)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .len_bytes_i   (len_bytes_i),
      .num_frames_i  (num_frames_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .frames_sent_o (frames_sent_o),
      .s_tdata_o     (s_tdata_o),
      .s_tvalid_o    (s_tvalid_o),
      .s_tready_i    (s_tready_i),
      .s_tlast_o     (s_tlast_o),
      .s_tkeep_o     (s_tkeep_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]  cap_dat[$];
   logic [KW-1:0] cap_keep[$];

   typedef struct {
      int len;
      int nfr;
      bit rnd;
      int beats;
      int sent;
   } vec_t;

   vec_t tab[7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference beat built byte by byte from the frame index and the in-frame byte offset.
   function automatic logic [W+KW:0] model_beat(input int len, input int f, input int b);
      logic [W-1:0]  d;
      logic [KW-1:0] k;
      int nb;
      int kk;
      d  = '0;
      k  = '0;
      nb = (len + KW - 1) / KW;
      for (int i = 0; i < KW; i++) begin
         kk = b * KW + i;
         if (kk < len) begin
            k[i]          = 1'b1;
            d[i*8 +: 8]   = 8'(f + kk);
         end
      end
      return {d, k, (b == nb - 1)};
   endfunction

   task automatic run(input int len, input int nfr, input bit rnd, output int nbeats, output int done_idx);
      int f = 0;
      int b = 0;
      int nb;
      int gapc = 0;
      bit injected = 0;
      bit in_gap = 0;
      bit stalled = 0;
      logic [W+KW:0] hold;
      nb = (len + KW - 1) / KW;
      cap_dat.delete();
      cap_keep.delete();
      nbeats   = 0;
      done_idx = -1;
      start_i      = 1'b1;
      len_bytes_i  = 16'(len);
      num_frames_i = 16'(nfr);
      s_tready_i   = 1'b1;
      @(posedge clk_i); #1;
      start_i      = 1'b0;
      len_bytes_i  = 16'd3;
      num_frames_i = 16'd9;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 0) chk("sent_clr", frames_sent_o, 16'd0);
         if (stalled) chk("hold", {s_tvalid_o, s_tdata_o, s_tkeep_o, s_tlast_o}, {1'b1, hold});
         if (!injected && busy_o) begin
            start_i  = 1'b1;
            injected = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         if (done_o) begin
            done_idx = cyc;
            break;
         end
         s_tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (s_tvalid_o) begin
            if (in_gap) begin
               chk("gap_len", gapc, GAPX);
               in_gap = 1'b0;
            end
            if (s_tready_i) begin
               chk("beat", {s_tdata_o, s_tkeep_o, s_tlast_o}, model_beat(len, f, b));
               cap_dat.push_back(s_tdata_o);
               cap_keep.push_back(s_tkeep_o);
               nbeats++;
               if (b == nb - 1) begin
                  b      = 0;
                  f++;
                  in_gap = 1'b1;
                  gapc   = 0;
               end else begin
                  b++;
               end
            end else begin
               stalled = 1'b1;
               hold    = {s_tdata_o, s_tkeep_o, s_tlast_o};
            end
         end else if (in_gap) begin
            gapc++;
         end
         @(posedge clk_i); #1;
      end
      if (done_idx < 0) chk("done_timeout", 0, 1);
      @(posedge clk_i); #1;
      start_i    = 1'b0;
      s_tready_i = 1'b1;
   endtask

   int nbeats;
   int didx;
   int exp_idx;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{len: 20,  nfr: 1, rnd: 1'b0, beats: 3,  sent: 1};
      tab[1] = '{len: 16,  nfr: 3, rnd: 1'b0, beats: 6,  sent: 3};
      tab[2] = '{len: 0,   nfr: 5, rnd: 1'b0, beats: 0,  sent: 0};
      tab[3] = '{len: 7,   nfr: 0, rnd: 1'b0, beats: 0,  sent: 0};
      tab[4] = '{len: 37,  nfr: 2, rnd: 1'b1, beats: 10, sent: 2};
      tab[5] = '{len: 1,   nfr: 3, rnd: 1'b0, beats: 3,  sent: 3};
      tab[6] = '{len: 300, nfr: 1, rnd: 1'b1, beats: 38, sent: 1};

      rst_ni       = 1'b0;
      start_i      = 1'b0;
      len_bytes_i  = 16'd0;
      num_frames_i = 16'd0;
      s_tready_i   = 1'b1;
      #12;
      chk("reset_outs", {s_tvalid_o, s_tlast_o, busy_o, done_o, frames_sent_o, s_tdata_o, s_tkeep_o}, '0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("idle_after_reset", {s_tvalid_o, busy_o}, 2'b00);

      // Scenario 1: 20-byte single frame.
      run(20, 1, 1'b0, nbeats, didx);
      chk("s1_beats", nbeats, 3);
      chk("s1_keep", {cap_keep[0], cap_keep[1], cap_keep[2]}, 24'hFFFF0F);
      chk("s1_beat2", cap_dat[2], 64'h00000000_13121110);
      chk("s1_sent", frames_sent_o, 16'd1);

      // Scenario 2: first byte of each frame follows the frame index.
      run(16, 3, 1'b0, nbeats, didx);
      chk("s2_f1_byte0", cap_dat[2][7:0], 8'h01);
      chk("s2_f2_byte0", cap_dat[4][7:0], 8'h02);

      for (int t = 0; t < 7; t++) begin
         run(tab[t].len, tab[t].nfr, tab[t].rnd, nbeats, didx);
         chk("tab_beats", nbeats, tab[t].beats);
         if (!tab[t].rnd) begin
            exp_idx = (tab[t].beats == 0) ? 0 : tab[t].beats + (tab[t].nfr - 1) * GAPX;
            chk("tab_done_cycle", didx, exp_idx);
         end
         chk("tab_post", {done_o, busy_o, frames_sent_o}, {1'b0, 1'b0, 16'(tab[t].sent)});
         repeat (2) @(posedge clk_i);
         #1;
         chk("tab_sent_hold", frames_sent_o, 16'(tab[t].sent));
      end

      // Scenario 6: reset in the middle of a frame, then a fresh run restarts the pattern.
      start_i      = 1'b1;
      len_bytes_i  = 16'd64;
      num_frames_i = 16'd2;
      s_tready_i   = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #3;
      chk("pre_rst_busy", {s_tvalid_o, busy_o}, 2'b11);
      rst_ni = 1'b0;
      #1;
      chk("midrst_outs", {s_tvalid_o, s_tlast_o, busy_o, done_o, frames_sent_o, s_tdata_o, s_tkeep_o}, '0);
      #2;
      rst_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("postrst_idle", {s_tvalid_o, busy_o}, 2'b00);
      run(16, 1, 1'b0, nbeats, didx);
      chk("postrst_beats", nbeats, 2);
      chk("postrst_byte0", cap_dat[0][7:0], 8'h00);
      chk("postrst_sent", frames_sent_o, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4s_frame_gen.md
AXI4S_FRAME_GEN -- requirements
Module: axi4s_frame_gen

Interface
REQ-001 The block SHALL have parameter AXI_WIDTH, default 64, giving the tdata width in bits (multiple of 8, 8..512).
REQ-002 The block SHALL have parameter IFG_CYCLES, default 4, giving the idle cycles between frames when the gap feature is compiled in (1..255).
REQ-003 Port clk_i, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 Port start_i, input, 1, one-cycle request to begin a run.
REQ-006 Port len_bytes_i, input, 16, frame length in bytes.
REQ-007 Port num_frames_i, input, 16, number of frames in the run.
REQ-008 Port busy_o, output, 1, high while a run is in progress.
REQ-009 Port done_o, output, 1, one-cycle pulse at the end of a run.
REQ-010 Port frames_sent_o, output, 16, count of completed frames in the current or last run.
REQ-011 Port s_tdata_o, output, AXI_WIDTH, stream data.
REQ-012 Port s_tvalid_o, output, 1, stream valid.
REQ-013 Port s_tready_i, input, 1, stream ready from the downstream consumer.
REQ-014 Port s_tlast_o, output, 1, last beat of a frame.
REQ-015 Port s_tkeep_o, output, AXI_WIDTH/8, byte enables.

Function
REQ-016 The block SHALL implement the FSM states IDLE, SEND, GAP and DONE, with these transitions:
- IDLE->SEND on start_i with len_bytes_i!=0 and num_frames_i!=0.
- IDLE->DONE on start_i with either input zero.
- SEND->GAP, or SEND->SEND when the gap feature is out, on an accepted tlast beat with frames remaining.
- SEND->DONE on an accepted tlast beat of the final frame.
- GAP->SEND after IFG_CYCLES cycles.
- DONE->IDLE unconditionally.
REQ-017 The block SHALL capture len_bytes_i and num_frames_i on the start cycle, and SHALL ignore later input changes for the rest of the run.
REQ-018 The block SHALL ignore start_i when not in IDLE.
REQ-019 The block SHALL assert s_tvalid_o on the cycle after start_i is accepted (latency 1).
REQ-020 The block SHALL assert s_tvalid_o only in SEND.
REQ-021 A beat SHALL transfer when s_tvalid_o and s_tready_i are both high.
REQ-022 While s_tvalid_o is high and s_tready_i is low, s_tdata_o, s_tkeep_o and s_tlast_o SHALL be held stable.
REQ-023 Once asserted, s_tvalid_o SHALL NOT drop until the beat transfers.
REQ-024 Each frame SHALL be ceil(len/(AXI_WIDTH/8)) beats long.
REQ-025 s_tlast_o SHALL be high only on the final beat of a frame.
REQ-026 s_tkeep_o SHALL be all ones except on the final beat, where the low (len mod (AXI_WIDTH/8)) bits SHALL be set, or all bits when that remainder is 0.
REQ-027 Byte k of frame f, counting from the start of the frame with byte lane 0 first, SHALL be (f[7:0]+k) mod 256.
REQ-028 Byte lanes with tkeep low SHALL be driven to 0x00.
REQ-029 frames_sent_o SHALL clear on start acceptance.
REQ-030 frames_sent_o SHALL increment on every accepted tlast beat.
REQ-031 frames_sent_o SHALL hold its value after DONE until the next start.
REQ-032 done_o SHALL be high for exactly one cycle, in DONE.
REQ-033 busy_o SHALL be high in SEND, GAP and DONE.
REQ-034 The block SHALL generate full back-to-back bursts when s_tready_i is held high, with no bubbles inside a frame.

Reset
REQ-035 When rst_ni is low, the FSM SHALL enter IDLE immediately, including mid-frame and mid-gap.
REQ-036 While rst_ni is low, s_tvalid_o, s_tlast_o, busy_o and done_o SHALL be 0.
REQ-037 While rst_ni is low, frames_sent_o, s_tdata_o and s_tkeep_o SHALL be 0.
REQ-038 After rst_ni deasserts, s_tvalid_o SHALL stay low until a start is accepted.

Configuration
REQ-039 With AXI4S_FRAME_GEN_GAP_EN defined, the block SHALL insert exactly IFG_CYCLES cycles with s_tvalid_o low between consecutive frames, and none after the final frame.
REQ-040 With AXI4S_FRAME_GEN_GAP_EN undefined, the GAP state and IFG_CYCLES SHALL have no effect, and the first beat of the next frame SHALL be presented on the cycle after the accepted tlast.

Verification
REQ-041 Scenario 1: AXI_WIDTH=64, len=20, frames=1, tready=1. Required response:
- 3 beats.
- tkeep FF,FF,0F.
- Beat 2 data 0x00000000_13121110.
- tlast on beat 2.
- done_o pulses once.
- frames_sent_o=1.
REQ-042 Scenario 2: len=16, frames=3, gap feature out, tready=1. Required response:
- 6 consecutive valid beats.
- Frame 1 first byte 0x01; frame 2 first byte 0x02.
- frames_sent_o=3.
REQ-043 Scenario 3: same run as Scenario 2 with AXI4S_FRAME_GEN_GAP_EN defined and IFG_CYCLES=4. Required response: exactly 4 cycles with tvalid low between each frame.
REQ-044 Scenario 4: tready random 50%. Required response:
- No data, keep or last change while valid and not ready.
- Byte pattern gapless.
- No dropped or duplicated beats.
REQ-045 Scenario 5: start with len=0. Required response:
- No tvalid.
- done_o high on the next cycle.
- frames_sent_o=0.
- A second start pulse while busy is ignored.
REQ-046 Scenario 6: rst_ni low mid-frame. Required response:
- tvalid=0 and busy=0 immediately.
- A fresh start afterwards begins the pattern at frame 0, byte 0x00.
